// File: rtl/icb_arbt_rr_pkg.sv
// Shared definitions for the ICB round-robin/priority arbiter.
package icb_arbt_rr_pkg;

    localparam int ARBT_PRIO = 0;
    localparam int ARBT_RR   = 1;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/icb_arbt_rr_fifo.sv
// Small synchronous FIFO holding the ids of commands awaiting their response.
module icb_arbt_rr_fifo
    import icb_arbt_rr_pkg::*;
#(
    parameter int CUT_READY = 1,
    parameter int DP        = 2,
    parameter int DW        = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat
);
    localparam int PW = clog2_min1(DP);
    localparam int CW = clog2_min1(DP + 1);

    logic [DW-1:0] mem [DP];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          full;
    logic          push;
    logic          pop;

    assign full  = (cnt == CW'(DP));
    assign o_vld = (cnt != '0);
    // With CUT_READY a full FIFO refuses writes even while it is being drained.
    assign i_rdy = (CUT_READY != 0) ? ~full : (~full | o_rdy);
    assign push  = i_vld & i_rdy;
    assign pop   = o_vld & o_rdy;
    assign o_dat = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= (wptr == PW'(DP - 1)) ? '0 : wptr + 1'b1;
            if (pop)  rptr <= (rptr == PW'(DP - 1)) ? '0 : rptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= i_dat;
    end

endmodule

// File: rtl/icb_arbt_rr.sv
// N-to-1 ICB arbiter: fixed-priority or round-robin command grant, in-order response routing.
module icb_arbt_rr
    import icb_arbt_rr_pkg::*;
#(
    parameter int AW              = 32,
    parameter int DW              = 64,
    parameter int USR_W           = 1,
    parameter int ARBT_NUM        = 4,
    parameter int ARBT_SCHEME     = 1,
    parameter int FIFO_DP         = 2,
    parameter int ALLOW_0CYCL_RSP = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ARBT_NUM-1:0]         i_bus_icb_cmd_vld,
    output logic [ARBT_NUM-1:0]         i_bus_icb_cmd_rdy,
    input  logic [ARBT_NUM-1:0]         i_bus_icb_cmd_read,
    input  logic [ARBT_NUM*AW-1:0]      i_bus_icb_cmd_addr,
    input  logic [ARBT_NUM*DW-1:0]      i_bus_icb_cmd_wdata,
    input  logic [ARBT_NUM*DW/8-1:0]    i_bus_icb_cmd_wmask,
    input  logic [ARBT_NUM*USR_W-1:0]   i_bus_icb_cmd_usr,
    output logic [ARBT_NUM-1:0]         i_bus_icb_rsp_vld,
    input  logic [ARBT_NUM-1:0]         i_bus_icb_rsp_rdy,
    output logic [ARBT_NUM-1:0]         i_bus_icb_rsp_err,
    output logic [ARBT_NUM*DW-1:0]      i_bus_icb_rsp_rdata,
    output logic [ARBT_NUM*USR_W-1:0]   i_bus_icb_rsp_usr,
    output logic                        o_icb_cmd_vld,
    input  logic                        o_icb_cmd_rdy,
    output logic                        o_icb_cmd_read,
    output logic [AW-1:0]               o_icb_cmd_addr,
    output logic [DW-1:0]               o_icb_cmd_wdata,
    output logic [DW/8-1:0]             o_icb_cmd_wmask,
    output logic [USR_W-1:0]            o_icb_cmd_usr,
    input  logic                        o_icb_rsp_vld,
    output logic                        o_icb_rsp_rdy,
    input  logic                        o_icb_rsp_err,
    input  logic [DW-1:0]               o_icb_rsp_rdata,
    input  logic [USR_W-1:0]            o_icb_rsp_usr
);
    localparam int IDW = clog2_min1(ARBT_NUM);
    localparam int MW  = DW / 8;

    assign i_bus_icb_rsp_err   = {ARBT_NUM{o_icb_rsp_err}};
    assign i_bus_icb_rsp_rdata = {ARBT_NUM{o_icb_rsp_rdata}};
    assign i_bus_icb_rsp_usr   = {ARBT_NUM{o_icb_rsp_usr}};

    generate
        if (ARBT_NUM == 1) begin : g_pass
            assign o_icb_cmd_vld     = i_bus_icb_cmd_vld;
            assign i_bus_icb_cmd_rdy = o_icb_cmd_rdy;
            assign o_icb_cmd_read    = i_bus_icb_cmd_read;
            assign o_icb_cmd_addr    = i_bus_icb_cmd_addr;
            assign o_icb_cmd_wdata   = i_bus_icb_cmd_wdata;
            assign o_icb_cmd_wmask   = i_bus_icb_cmd_wmask;
            assign o_icb_cmd_usr     = i_bus_icb_cmd_usr;
            assign i_bus_icb_rsp_vld = o_icb_rsp_vld;
            assign o_icb_rsp_rdy     = i_bus_icb_rsp_rdy;
        end else begin : g_arb
            logic           held;
            logic [IDW-1:0] held_id;
            logic [IDW-1:0] rr_ptr;
            logic [IDW-1:0] pick;
            logic [IDW-1:0] idx;
            logic [IDW-1:0] winner;
            logic [IDW-1:0] head;
            logic [IDW-1:0] route;
            logic           winner_vld;
            logic           fifo_rdy;
            logic           fifo_vld;
            logic           route_ok;
            logic           hs_cmd;
            logic           hs_rsp;
            logic           bypass;
            logic           push;
            logic           pop;

            // Scan downward so the earliest port in scan order is the last (winning) assignment.
            always_comb begin
                pick = '0;
                idx  = '0;
                if (ARBT_SCHEME == ARBT_RR) begin
                    pick = rr_ptr;
                    for (int i = ARBT_NUM - 1; i >= 0; i--) begin
                        idx = IDW'((int'(rr_ptr) + i) % ARBT_NUM);
                        if (i_bus_icb_cmd_vld[idx]) pick = idx;
                    end
                end else begin
                    for (int i = ARBT_NUM - 1; i >= 0; i--) begin
                        if (i_bus_icb_cmd_vld[IDW'(i)]) pick = IDW'(i);
                    end
                end
            end

            assign winner     = held ? held_id : pick;
            assign winner_vld = i_bus_icb_cmd_vld[winner];
            assign o_icb_cmd_vld = rst & winner_vld & fifo_rdy;
            assign hs_cmd     = o_icb_cmd_vld & o_icb_cmd_rdy;

            assign o_icb_cmd_read  = i_bus_icb_cmd_read[winner];
            assign o_icb_cmd_addr  = i_bus_icb_cmd_addr[int'(winner)*AW +: AW];
            assign o_icb_cmd_wdata = i_bus_icb_cmd_wdata[int'(winner)*DW +: DW];
            assign o_icb_cmd_wmask = i_bus_icb_cmd_wmask[int'(winner)*MW +: MW];
            assign o_icb_cmd_usr   = i_bus_icb_cmd_usr[int'(winner)*USR_W +: USR_W];

            // An empty FIFO routes to the current winner only when zero-cycle responses are allowed.
            assign route_ok = fifo_vld | (ALLOW_0CYCL_RSP != 0);
            assign route    = fifo_vld ? head : winner;
            assign o_icb_rsp_rdy = rst & route_ok & i_bus_icb_rsp_rdy[route];
            assign hs_rsp   = o_icb_rsp_vld & o_icb_rsp_rdy;

            always_comb begin
                i_bus_icb_cmd_rdy = '0;
                i_bus_icb_rsp_vld = '0;
                for (int k = 0; k < ARBT_NUM; k++) begin
                    i_bus_icb_cmd_rdy[IDW'(k)] = rst & o_icb_cmd_rdy & fifo_rdy & (winner == IDW'(k));
                    i_bus_icb_rsp_vld[IDW'(k)] = rst & route_ok & o_icb_rsp_vld & (route == IDW'(k));
                end
            end

            assign bypass = ~fifo_vld & hs_cmd & hs_rsp;
            assign push   = hs_cmd & ~bypass;
            assign pop    = hs_rsp & fifo_vld;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    held    <= 1'b0;
                    held_id <= '0;
                    rr_ptr  <= '0;
                end else if (hs_cmd) begin
                    held   <= 1'b0;
                    rr_ptr <= (winner == IDW'(ARBT_NUM - 1)) ? '0 : winner + 1'b1;
                end else if (o_icb_cmd_vld) begin
                    held    <= 1'b1;
                    held_id <= winner;
                end
            end

            icb_arbt_rr_fifo #(
                .CUT_READY (1),
                .DP        (FIFO_DP),
                .DW        (IDW)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .i_vld (push),
                .i_rdy (fifo_rdy),
                .i_dat (winner),
                .o_vld (fifo_vld),
                .o_rdy (pop),
                .o_dat (head)
            );
        end
    endgenerate

endmodule

// File: tb/tb_icb_arbt_rr.sv
// Directed bench for icb_arbt_rr: vector table plus hold/full/order/reset/priority sequences.
module tb_icb_arbt_rr;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MW = DW / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      vld = '0;
    logic [N-1:0]      rd = '0;
    logic [N*AW-1:0]   addr = '0;
    logic [N*DW-1:0]   wdata = '0;
    logic [N*MW-1:0]   wmask = '0;
    logic [N-1:0]      usr = '0;
    logic [N-1:0]      rrdy = '0;
    logic              crdy = 1'b0;
    logic              rvld = 1'b0;
    logic              rerr = 1'b0;
    logic [DW-1:0]     rdata = '0;
    logic [0:0]        rusr = '0;

    logic [N-1:0]      irdy, irvld, irerr, iruser;
    logic [N*DW-1:0]   irdata;
    logic              ovld, oread, orrdy;
    logic [AW-1:0]     oaddr;
    logic [DW-1:0]     owdata;
    logic [MW-1:0]     owmask;
    logic [0:0]        ousr;

    logic [N-1:0]      p_irdy, p_irvld, p_irerr, p_iruser;
    logic [N*DW-1:0]   p_irdata;
    logic              p_ovld, p_oread, p_orrdy;
    logic [AW-1:0]     p_oaddr;
    logic [DW-1:0]     p_owdata;
    logic [MW-1:0]     p_owmask;
    logic [0:0]        p_ousr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icb_arbt_rr u_rr (
        .clk(clk), .rst(rst),
        .i_bus_icb_cmd_vld(vld), .i_bus_icb_cmd_rdy(irdy), .i_bus_icb_cmd_read(rd),
        .i_bus_icb_cmd_addr(addr), .i_bus_icb_cmd_wdata(wdata), .i_bus_icb_cmd_wmask(wmask),
        .i_bus_icb_cmd_usr(usr), .i_bus_icb_rsp_vld(irvld), .i_bus_icb_rsp_rdy(rrdy),
        .i_bus_icb_rsp_err(irerr), .i_bus_icb_rsp_rdata(irdata), .i_bus_icb_rsp_usr(iruser),
        .o_icb_cmd_vld(ovld), .o_icb_cmd_rdy(crdy), .o_icb_cmd_read(oread),
        .o_icb_cmd_addr(oaddr), .o_icb_cmd_wdata(owdata), .o_icb_cmd_wmask(owmask),
        .o_icb_cmd_usr(ousr), .o_icb_rsp_vld(rvld), .o_icb_rsp_rdy(orrdy),
        .o_icb_rsp_err(rerr), .o_icb_rsp_rdata(rdata), .o_icb_rsp_usr(rusr)
    );

    icb_arbt_rr #(.ARBT_SCHEME(0)) u_prio (
        .clk(clk), .rst(rst),
        .i_bus_icb_cmd_vld(vld), .i_bus_icb_cmd_rdy(p_irdy), .i_bus_icb_cmd_read(rd),
        .i_bus_icb_cmd_addr(addr), .i_bus_icb_cmd_wdata(wdata), .i_bus_icb_cmd_wmask(wmask),
        .i_bus_icb_cmd_usr(usr), .i_bus_icb_rsp_vld(p_irvld), .i_bus_icb_rsp_rdy(rrdy),
        .i_bus_icb_rsp_err(p_irerr), .i_bus_icb_rsp_rdata(p_irdata), .i_bus_icb_rsp_usr(p_iruser),
        .o_icb_cmd_vld(p_ovld), .o_icb_cmd_rdy(crdy), .o_icb_cmd_read(p_oread),
        .o_icb_cmd_addr(p_oaddr), .o_icb_cmd_wdata(p_owdata), .o_icb_cmd_wmask(p_owmask),
        .o_icb_cmd_usr(p_ousr), .o_icb_rsp_vld(rvld), .o_icb_rsp_rdy(p_orrdy),
        .o_icb_rsp_err(rerr), .o_icb_rsp_rdata(rdata), .o_icb_rsp_usr(rusr)
    );

    typedef struct {
        logic [3:0] vld;
        logic       crdy;
        logic       rvld;
        logic [3:0] rrdy;
        logic       ovld;
        logic [3:0] irdy;
        int         gnt;
        logic [3:0] irvld;
        logic       orrdy;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic cr, input logic rv, input logic [3:0] rr);
        vld  = v;
        crdy = cr;
        rvld = rv;
        rrdy = rr;
    endtask

    task automatic do_reset();
        drive(4'b0000, 1'b0, 1'b0, 4'b0000);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            addr[k*AW +: AW]  = 32'h1000 + k;
            wdata[k*DW +: DW] = 64'hD000 + k;
            wmask[k*MW +: MW] = 8'h10 + 8'(k);
            rd[k]  = k[0];
            usr[k] = k[1];
        end

        // vld | crdy | rvld | rrdy || ovld | irdy | gnt | irvld | orrdy
        tv[0]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, 0, 4'b0001, 1'b1};
        tv[1]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0010, 1, 4'b0010, 1'b1};
        tv[2]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100, 2, 4'b0100, 1'b1};
        tv[3]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1000, 3, 4'b1000, 1'b1};
        tv[4]  = '{4'b1111, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, 0, 4'b0001, 1'b1};
        tv[5]  = '{4'b1010, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0010, 1, 4'b0010, 1'b1};
        tv[6]  = '{4'b1010, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1000, 3, 4'b1000, 1'b1};
        tv[7]  = '{4'b0110, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0010, 1, 4'b0010, 1'b1};
        tv[8]  = '{4'b0001, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, 0, 4'b0001, 1'b1};
        tv[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0000, 0, 4'b0000, 1'b0};
        tv[10] = '{4'b0100, 1'b1, 1'b1, 4'b1011, 1'b1, 4'b0100, 2, 4'b0100, 1'b0};
        tv[11] = '{4'b0000, 1'b0, 1'b1, 4'b1111, 1'b0, 4'b0000, 0, 4'b0100, 1'b1};

        // reset state
        drive(4'b1111, 1'b1, 1'b1, 4'b1111);
        #2;
        chk("rst_ovld", ovld, 0);
        chk("rst_irdy", irdy, 0);
        chk("rst_irvld", irvld, 0);

        do_reset();
        for (int r = 0; r < 12; r++) begin
            drive(tv[r].vld, tv[r].crdy, tv[r].rvld, tv[r].rrdy);
            #1;
            chk($sformatf("row%0d_ovld", r), ovld, tv[r].ovld);
            chk($sformatf("row%0d_irdy", r), irdy, tv[r].irdy);
            chk($sformatf("row%0d_irvld", r), irvld, tv[r].irvld);
            chk($sformatf("row%0d_orrdy", r), orrdy, tv[r].orrdy);
            if (tv[r].ovld) begin
                chk($sformatf("row%0d_addr", r), oaddr, 64'h1000 + 64'(tv[r].gnt));
                chk($sformatf("row%0d_wdata", r), owdata, 64'hD000 + 64'(tv[r].gnt));
            end
            cyc();
        end

        // grant hold, then FIFO full and release
        do_reset();
        drive(4'b0100, 1'b0, 1'b0, 4'b1111);
        #1;
        chk("hold_c1_ovld", ovld, 1);
        chk("hold_c1_addr", oaddr, 32'h1002);
        chk("hold_c1_irdy", irdy, 4'b0000);
        cyc();
        for (int c = 2; c <= 3; c++) begin
            drive(4'b0101, 1'b0, 1'b0, 4'b1111);
            #1;
            chk($sformatf("hold_c%0d_addr", c), oaddr, 32'h1002);
            chk($sformatf("hold_c%0d_wmask", c), owmask, 8'h12);
            cyc();
        end
        drive(4'b0101, 1'b1, 1'b0, 4'b1111);
        #1;
        chk("hold_c4_irdy", irdy, 4'b0100);
        chk("hold_c4_addr", oaddr, 32'h1002);
        cyc();
        drive(4'b0001, 1'b1, 1'b0, 4'b1111);
        #1;
        chk("full_c5_irdy", irdy, 4'b0001);
        cyc();
        drive(4'b0001, 1'b1, 1'b1, 4'b1111);
        #1;
        chk("full_c6_ovld", ovld, 0);
        chk("full_c6_irdy", irdy, 4'b0000);
        chk("full_c6_irvld", irvld, 4'b0100);
        chk("full_c6_orrdy", orrdy, 1);
        cyc();
        drive(4'b0001, 1'b1, 1'b0, 4'b1111);
        #1;
        chk("full_c7_ovld", ovld, 1);
        chk("full_c7_irdy", irdy, 4'b0001);
        cyc();

        // response ordering: port 3 then port 1
        do_reset();
        drive(4'b1000, 1'b1, 1'b0, 4'b1111);
        #1;
        chk("ord_cmd3_irdy", irdy, 4'b1000);
        chk("ord_cmd3_addr", oaddr, 32'h1003);
        cyc();
        drive(4'b0010, 1'b1, 1'b0, 4'b1111);
        #1;
        chk("ord_cmd1_irdy", irdy, 4'b0010);
        cyc();
        drive(4'b0000, 1'b0, 1'b1, 4'b1111);
        rdata = 64'hAAAA_0000_1234_5678;
        #1;
        chk("ord_rsp1_irvld", irvld, 4'b1000);
        chk("ord_rsp1_rdata3", irdata[3*DW +: DW], 64'hAAAA_0000_1234_5678);
        chk("ord_rsp1_rdata1", irdata[1*DW +: DW], 64'hAAAA_0000_1234_5678);
        cyc();
        rdata = 64'hBBBB_0000_8765_4321;
        #1;
        chk("ord_rsp2_irvld", irvld, 4'b0010);
        chk("ord_rsp2_rdata1", irdata[1*DW +: DW], 64'hBBBB_0000_8765_4321);
        cyc();
        drive(4'b0000, 1'b0, 1'b0, 4'b1111);
        #1;
        chk("ord_idle_irvld", irvld, 4'b0000);
        cyc();

        // reset with two outstanding
        drive(4'b1000, 1'b1, 1'b0, 4'b1111);
        cyc();
        drive(4'b0010, 1'b1, 1'b0, 4'b1111);
        cyc();
        drive(4'b0001, 1'b1, 1'b1, 4'b1111);
        #1 rst = 1'b0;
        #1;
        chk("mrst_ovld", ovld, 0);
        chk("mrst_irdy", irdy, 4'b0000);
        chk("mrst_irvld", irvld, 4'b0000);
        @(posedge clk);
        #1 rst = 1'b1;
        drive(4'b0001, 1'b1, 1'b0, 4'b1111);
        #1;
        chk("mrst_new_irdy", irdy, 4'b0001);
        cyc();
        drive(4'b0000, 1'b0, 1'b1, 4'b1111);
        #1;
        chk("mrst_rsp_irvld", irvld, 4'b0001);
        cyc();

        // fixed priority instance
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(4'b1010, 1'b1, 1'b1, 4'b1111);
            #1;
            chk($sformatf("prio_c%0d_irdy", c), p_irdy, 4'b0010);
            chk($sformatf("prio_c%0d_addr", c), p_oaddr, 32'h1001);
            cyc();
        end
        drive(4'b1000, 1'b1, 1'b1, 4'b1111);
        #1;
        chk("prio_drop_irdy", p_irdy, 4'b1000);
        chk("prio_drop_addr", p_oaddr, 32'h1003);
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
